led_strip_frame_scheduler: RTL and testbench

- Frame sequencer and arbiter for the single 2-wire serial LED-strip link (APA102-style sclk/sdat) driving the 8x8 matrix.
- Grants whole frames round-robin to two pixel clients.
- For each frame it generates the start frame, then fetches each pixel from the granted client over a fixed-latency read port, serialises it with a brightness header, and appends the end frame.
- Sits between the scroll/overlay renderers and the pad outputs.

---
 rtl/led_strip_pkg.sv | 18 +
 rtl/led_strip_frame_scheduler_map.sv | 21 ++
 rtl/led_strip_frame_scheduler.sv | 157 +++++++++++++++
 tb/tb_led_strip_frame_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_strip_pkg.sv
// rtl/led_strip_pkg.sv - shared states and framing constants for the LED strip frame scheduler
package led_strip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        FETCH,
        PIXEL,
        END,
        DONE
    } state_t;

    localparam int          START_BITS = 32;
    localparam int          WORD_BITS  = 32;
    localparam logic [2:0]  HDR        = 3'b111;
    localparam int          ROW_LEN    = 8;

endpackage

// File: rtl/led_strip_frame_scheduler_map.sv
// rtl/led_strip_frame_scheduler_map.sv - physical LED to logical pixel address; LED_SERPENTINE_EN selects snake wiring
module led_serpentine_map
    import led_strip_pkg::*;
(
    input  logic [5:0] p,
    output logic [5:0] addr
);

`ifdef LED_SERPENTINE_EN
    // Even physical rows run right-to-left on the snake-wired matrix.
    always_comb begin
        addr = p;
        if (!p[3]) begin
            addr = {p[5:3], 3'(ROW_LEN - 1) - p[2:0]};
        end
    end
`else
    assign addr = p;
`endif

endmodule

// File: rtl/led_strip_frame_scheduler.sv
// rtl/led_strip_frame_scheduler.sv - round-robin frame arbiter and APA102-style serialiser; LED_SERPENTINE_EN selects pixel mapping
module led_strip_frame_scheduler
    import led_strip_pkg::*;
#(
    parameter int NUM_LEDS = 64,
    parameter int END_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  frame_req,
    output logic [1:0]  frame_gnt,
    output logic [1:0]  frame_done,
    input  logic [4:0]  bright,
    output logic        pix_rd,
    output logic [5:0]  pix_addr,
    input  logic [23:0] pix_data,
    output logic        busy,
    output logic        sclk,
    output logic        sdat
);

    localparam int EW = $clog2(END_BITS + 1);

    state_t          state;
    state_t          state_nx;
    logic            phase;
    logic [4:0]      bit_cnt;
    logic [5:0]      led;
    logic [EW-1:0]   end_cnt;
    logic [31:0]     shreg;
    logic [4:0]      bright_q;
    logic            last_gnt;
    logic [1:0]      win;
    logic [5:0]      map_addr;
    logic            word_end;
    logic            last_led;
    logic            end_last;

    led_serpentine_map u_map (
        .p    (led),
        .addr (map_addr)
    );

    assign word_end = phase && (bit_cnt == 5'd31);
    assign last_led = (led == 6'(NUM_LEDS - 1));
    assign end_last = phase && (end_cnt == EW'(END_BITS - 1));
    assign busy     = (state != IDLE);
    assign pix_addr = pix_rd ? map_addr : 6'd0;

    always_comb begin
        case (frame_req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_gnt ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sclk       = 1'b0;
        sdat       = 1'b0;
        pix_rd     = 1'b0;
        frame_done = 2'b00;
        case (state)
            IDLE: begin
                if (|frame_req) state_nx = START;
            end
            START: begin
                sclk = phase;
                if (word_end) state_nx = FETCH;
            end
            FETCH: begin
                pix_rd = !phase;
                if (phase) state_nx = PIXEL;
            end
            PIXEL: begin
                sclk = phase;
                sdat = shreg[31];
                if (word_end) state_nx = last_led ? END : FETCH;
            end
            END: begin
                sclk = phase;
                sdat = 1'b1;
                if (end_last) state_nx = DONE;
            end
            DONE: begin
                frame_done = frame_gnt;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= 1'b0;
            bit_cnt   <= 5'd0;
            led       <= 6'd0;
            end_cnt   <= '0;
            shreg     <= 32'd0;
            bright_q  <= 5'd0;
            frame_gnt <= 2'b00;
            last_gnt  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    phase   <= 1'b0;
                    bit_cnt <= 5'd0;
                    led     <= 6'd0;
                    end_cnt <= '0;
                    if (|frame_req) begin
                        frame_gnt <= win;
                        last_gnt  <= win[1];
                        bright_q  <= bright;
                    end
                end
                START: begin
                    phase <= ~phase;
                    if (phase) bit_cnt <= bit_cnt + 5'd1;
                end
                FETCH: begin
                    phase <= ~phase;
                    // Strip expects B,G,R after the brightness header.
                    if (phase) begin
                        shreg <= {HDR, bright_q, pix_data[7:0], pix_data[15:8], pix_data[23:16]};
                    end
                end
                PIXEL: begin
                    phase <= ~phase;
                    if (phase) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        shreg   <= {shreg[30:0], 1'b0};
                        if (bit_cnt == 5'd31 && !last_led) led <= led + 6'd1;
                    end
                end
                END: begin
                    phase <= ~phase;
                    if (phase) end_cnt <= end_cnt + 1'b1;
                end
                DONE: begin
                    frame_gnt <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_strip_frame_scheduler.sv
// tb/tb_led_strip_frame_scheduler.sv - directed bench for led_strip_frame_scheduler
module tb_led_strip_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  frame_req;
    logic [1:0]  frame_gnt;
    logic [1:0]  frame_done;
    logic [4:0]  bright;
    logic        pix_rd;
    logic [5:0]  pix_addr;
    logic [23:0] pix_data;
    logic        busy;
    logic        sclk;
    logic        sdat;

    int n_checks;
    int n_pass;
    int n_fail;

    int         busy_cnt, nbits, nrd, ncap, done_cnt;
    logic [1:0] last_done;
    logic       sclk_prev, rd_prev;
    logic       bits [0:2199];
    logic [5:0] addr_log [0:63];
    logic [23:0] cap [0:63];

    logic [23:0] base_data;
    logic        vary_en;
    logic [23:0] pat [0:4] = '{24'h123456, 24'hABCDEF, 24'h00FF00, 24'h5A5AA5, 24'h010203};
    int          cyc = 0;

    led_strip_frame_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_req  (frame_req),
        .frame_gnt  (frame_gnt),
        .frame_done (frame_done),
        .bright     (bright),
        .pix_rd     (pix_rd),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .busy       (busy),
        .sclk       (sclk),
        .sdat       (sdat)
    );

    always #5 clk = ~clk;

    // Pixel source: period 5 against a 66-cycle pixel slot so captures walk the whole table.
    always @(posedge clk) begin
        #2;
        pix_data = vary_en ? pat[cyc % 5] : base_data;
        cyc++;
    end

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (sclk && !sclk_prev) begin
            if (nbits < 2200) bits[nbits] = sdat;
            nbits++;
        end
        if (pix_rd) begin
            if (nrd < 64) addr_log[nrd] = pix_addr;
            nrd++;
        end
        if (rd_prev) begin
            if (ncap < 64) cap[ncap] = pix_data;
            ncap++;
        end
        if (frame_done != 2'b00) begin
            done_cnt++;
            last_done = frame_done;
        end
        sclk_prev = sclk;
        rd_prev   = pix_rd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        busy_cnt  = 0;
        nbits     = 0;
        nrd       = 0;
        ncap      = 0;
        done_cnt  = 0;
        last_done = 2'b00;
        sclk_prev = 1'b0;
        rd_prev   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic [1:0] d, output logic ok);
        ok = 1'b0;
        d  = 2'b00;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (frame_done != 2'b00) begin
                d  = frame_done;
                ok = 1'b1;
                break;
            end
        end
        step(1);
    endtask

    function automatic logic [31:0] word_at(input int i);
        logic [31:0] w;
        w = 32'd0;
        for (int b = 0; b < 32; b++) w = {w[30:0], bits[32 + 32*i + b]};
        return w;
    endfunction

    function automatic int ones(input int lo, input int hi);
        int n;
        n = 0;
        for (int k = lo; k <= hi; k++) if (bits[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic logic [5:0] exp_addr(input int p);
`ifdef LED_SERPENTINE_EN
        if (((p / 8) % 2) == 0) return 6'((p / 8) * 8 + 7 - (p % 8));
        return 6'(p);
`else
        return 6'(p);
`endif
    endfunction

    logic [1:0]  d;
    logic        ok;
    int          errs;
    logic        found;
    logic [31:0] w;
    logic [31:0] w123;
    logic [31:0] exp_w;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        reset     = 1'b1;
        frame_req = 2'b00;
        bright    = 5'h00;
        base_data = 24'h0;
        vary_en   = 1'b0;
        clr_mon();
        step(3);

        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_sdat", 32'(sdat), 0);
        chk("rst_gnt", 32'(frame_gnt), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_pix_rd", 32'(pix_rd), 0);
        chk("rst_pix_addr", 32'(pix_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        step(1);

        // Single frame from client 0 with constant green pixels.
        clr_mon();
        frame_req = 2'b01;
        bright    = 5'h10;
        base_data = 24'h00FF00;
        step(1);
        chk("t1_gnt", 32'(frame_gnt), 32'h1);
        chk("t1_busy", 32'(busy), 1);
        frame_req = 2'b00;
        wait_done(5000, d, ok);
        chk("t1_no_timeout", 32'(ok), 1);
        chk("t1_done_val", 32'(d), 32'h1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_sclk_edges", nbits, 2112);
        chk("t1_busy_cycles", busy_cnt, 4353);
        chk("t1_pix_rd_cnt", nrd, 64);
        chk("t1_start_ones", ones(0, 31), 0);
        chk("t1_end_ones", ones(2080, 2111), 32);
        errs = 0;
        for (int i = 0; i < 64; i++) if (word_at(i) !== 32'hF000FF00) errs++;
        chk("t1_word_errs", errs, 0);
        w = word_at(0);
        chk("t1_word0", w, 32'hF000FF00);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_gnt", 32'(frame_gnt), 0);

        errs = 0;
        for (int p = 0; p < 64; p++) if (addr_log[p] !== exp_addr(p)) errs++;
        chk("t3_addr_errs", errs, 0);
        chk("t3_addr0", 32'(addr_log[0]), 32'(exp_addr(0)));
        chk("t3_addr9", 32'(addr_log[9]), 32'(exp_addr(9)));
        chk("t3_addr16", 32'(addr_log[16]), 32'(exp_addr(16)));

        // Both clients requesting: round-robin from reset.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        clr_mon();
        frame_req = 2'b11;
        step(1);
        chk("t2_gnt1", 32'(frame_gnt), 32'h1);
        wait_done(5000, d, ok);
        chk("t2_done1", 32'(d), 32'h1);
        chk("t2_gap1_busy", 32'(busy), 0);
        step(1);
        chk("t2_gnt2", 32'(frame_gnt), 32'h2);
        chk("t2_busy2", 32'(busy), 1);
        wait_done(5000, d, ok);
        chk("t2_done2", 32'(d), 32'h2);
        chk("t2_gap2_busy", 32'(busy), 0);
        step(1);
        chk("t2_gnt3", 32'(frame_gnt), 32'h1);
        frame_req = 2'b00;
        wait_done(5000, d, ok);
        chk("t2_done3", 32'(d), 32'h1);
        step(1);
        chk("t2_stays_idle", 32'(busy), 0);
        chk("t2_done_cnt", done_cnt, 3);

        // Reset while shifting LED 20.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        clr_mon();
        frame_req = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (nrd >= 21) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_reach_led20", 32'(ok), 1);
        frame_req = 2'b00;
        step(10);
        chk("t4_in_frame", 32'(busy), 1);
        reset = 1'b1;
        step(1);
        chk("t4_sclk", 32'(sclk), 0);
        chk("t4_sdat", 32'(sdat), 0);
        chk("t4_gnt", 32'(frame_gnt), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(frame_done), 0);
        step(2);
        reset = 1'b0;
        step(2);
        chk("t4_no_done", done_cnt, 0);

        // Restart from client 1 with changing pixel data; request and brightness change mid-frame.
        clr_mon();
        vary_en   = 1'b1;
        bright    = 5'h10;
        frame_req = 2'b10;
        step(1);
        chk("t5_gnt", 32'(frame_gnt), 32'h2);
        step(99);
        frame_req = 2'b00;
        bright    = 5'h1F;
        wait_done(5000, d, ok);
        chk("t5_no_timeout", 32'(ok), 1);
        chk("t5_done_val", 32'(d), 32'h2);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_sclk_edges", nbits, 2112);
        chk("t5_start_ones", ones(0, 31), 0);
        chk("t5_cap_cnt", ncap, 64);
        w = word_at(63);
        chk("t5_hdr_latched", 32'(w[31:24]), 32'hF0);
        errs  = 0;
        found = 1'b0;
        w123  = 32'd0;
        for (int i = 0; i < 64; i++) begin
            exp_w = {3'b111, 5'h10, cap[i][7:0], cap[i][15:8], cap[i][23:16]};
            if (word_at(i) !== exp_w) errs++;
            if (cap[i] === 24'h123456 && !found) begin
                found = 1'b1;
                w123  = word_at(i);
            end
        end
        chk("t6_word_errs", errs, 0);
        chk("t6_found_123456", 32'(found), 1);
        chk("t6_word_123456", w123, 32'hF0563412);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
